// File: rtl/array_div.sv
// array_div: N-lane signed Q23.22 fixed-point divider, all lanes in lock-step.
// Radix-2 restoring division, one quotient bit per cycle, fixed 70-cycle latency.
// Quotients are rounded half away from zero and saturated to the W-bit range.
// Optional build macro ARRAY_DIV_STATUS_EN adds per-lane dbz/ovf status ports.
//
// Handshake: start is sampled only while idle (busy=0). The edge that samples
// start=1 captures dataa/datab and raises busy. busy stays high until the edge
// that raises done; done is a one-cycle pulse and result is valid from that cycle
// on, held until the next operation completes. start while busy is ignored.
module array_div #(
   parameter int N = 3,
   parameter int W = 45,
   parameter int F = 22
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [N-1:0][W-1:0]   dataa,
   input  logic [N-1:0][W-1:0]   datab,
   output logic                  busy,
   output logic                  done,
   output logic [N-1:0][W-1:0]   result
`ifdef ARRAY_DIV_STATUS_EN
   ,
   output logic [N-1:0]          dbz,
   output logic [N-1:0]          ovf
`endif
);

   // Dividend is |a| scaled by 2^(F+1): one extra fraction bit for rounding.
   localparam int QW = W + F + 1;
   localparam logic [6:0]    CNT_LAST = 7'(QW - 1);
   localparam logic [W-1:0]  RES_MAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  RES_MIN  = {1'b1, {(W-1){1'b0}}};
   localparam logic [QW-1:0] MAG_MAXP = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [QW-1:0] MAG_MAXN = {{(QW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

   // PREP turns the captured raw operands into sign/magnitude form, keeping the
   // negation off the input path; ITER runs QW steps; FIN rounds and saturates.
   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIN} state_e;

   state_e                 state_q, state_d;
   logic [6:0]             cnt_q, cnt_d;
   logic [N-1:0][W-1:0]    a_raw_q, a_raw_d;
   logic [N-1:0][W-1:0]    b_raw_q, b_raw_d;
   logic [N-1:0]           neg_q, neg_d;
   logic [N-1:0]           azero_q, azero_d;
   logic [N-1:0]           bzero_q, bzero_d;
   logic [N-1:0][W-1:0]    babs_q, babs_d;
   logic [N-1:0][QW-1:0]   quo_q, quo_d;
   logic [N-1:0][W-1:0]    rem_q, rem_d;
   logic [N-1:0][W-1:0]    result_q, result_d;
   logic                   done_q, done_d;
`ifdef ARRAY_DIV_STATUS_EN
   logic [N-1:0]           dbz_q, dbz_d;
   logic [N-1:0]           ovf_q, ovf_d;
`endif

   logic [N-1:0][W-1:0]    a_abs;
   logic [N-1:0][W-1:0]    b_abs;
   logic [N-1:0][W:0]      rem_sh;
   logic [N-1:0][QW-1:0]   mag;

   // Control sequencing: idle -> prep -> QW iterations -> finish -> idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_PREP;
         S_PREP: begin
            state_d = S_ITER;
            cnt_d   = CNT_LAST;
         end
         S_ITER: begin
            if (cnt_q == 7'd0) state_d = S_FIN;
            else               cnt_d   = cnt_q - 7'd1;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-lane datapath: capture, sign/magnitude prep, restoring step, round/saturate.
   always_comb begin
      a_raw_d  = a_raw_q;
      b_raw_d  = b_raw_q;
      neg_d    = neg_q;
      azero_d  = azero_q;
      bzero_d  = bzero_q;
      babs_d   = babs_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      result_d = result_q;
      done_d   = 1'b0;
`ifdef ARRAY_DIV_STATUS_EN
      dbz_d    = dbz_q;
      ovf_d    = ovf_q;
`endif
      a_abs    = '0;
      b_abs    = '0;
      rem_sh   = '0;
      mag      = '0;

      for (int k = 0; k < N; k++) begin
         a_abs[k]  = a_raw_q[k][W-1] ? -a_raw_q[k] : a_raw_q[k];
         b_abs[k]  = b_raw_q[k][W-1] ? -b_raw_q[k] : b_raw_q[k];
         rem_sh[k] = {rem_q[k], quo_q[k][QW-1]};
         // Round half away from zero on the magnitude: (Q2 + 1) >> 1.
         mag[k]    = {1'b0, quo_q[k][QW-1:1]} + QW'(quo_q[k][0]);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_raw_d = dataa;
               b_raw_d = datab;
            end
         end
         S_PREP: begin
            for (int k = 0; k < N; k++) begin
               neg_d[k]   = a_raw_q[k][W-1] ^ b_raw_q[k][W-1];
               azero_d[k] = (a_raw_q[k] == '0);
               bzero_d[k] = (b_raw_q[k] == '0);
               babs_d[k]  = b_abs[k];
               quo_d[k]   = {a_abs[k], {(F+1){1'b0}}};
               rem_d[k]   = '0;
            end
         end
         S_ITER: begin
            // Dividend bits leave quo at the top while quotient bits enter at the bottom.
            for (int k = 0; k < N; k++) begin
               if (rem_sh[k] >= {1'b0, babs_q[k]}) begin
                  rem_d[k] = W'(rem_sh[k] - {1'b0, babs_q[k]});
                  quo_d[k] = {quo_q[k][QW-2:0], 1'b1};
               end else begin
                  rem_d[k] = rem_sh[k][W-1:0];
                  quo_d[k] = {quo_q[k][QW-2:0], 1'b0};
               end
            end
         end
         S_FIN: begin
            done_d = 1'b1;
            for (int k = 0; k < N; k++) begin
`ifdef ARRAY_DIV_STATUS_EN
               dbz_d[k] = bzero_q[k];
               ovf_d[k] = 1'b0;
`endif
               if (bzero_q[k]) begin
                  // Divide by zero saturates toward the dividend's sign.
                  if (azero_q[k])    result_d[k] = '0;
                  else if (neg_q[k]) result_d[k] = RES_MIN;
                  else               result_d[k] = RES_MAX;
               end else if (neg_q[k]) begin
                  if (mag[k] > MAG_MAXN) begin
                     result_d[k] = RES_MIN;
`ifdef ARRAY_DIV_STATUS_EN
                     ovf_d[k] = 1'b1;
`endif
                  end else begin
                     result_d[k] = -mag[k][W-1:0];
                  end
               end else begin
                  if (mag[k] > MAG_MAXP) begin
                     result_d[k] = RES_MAX;
`ifdef ARRAY_DIV_STATUS_EN
                     ovf_d[k] = 1'b1;
`endif
                  end else begin
                     result_d[k] = mag[k][W-1:0];
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Control and visible outputs; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
`ifdef ARRAY_DIV_STATUS_EN
         dbz_q    <= '0;
         ovf_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
`ifdef ARRAY_DIV_STATUS_EN
         dbz_q    <= dbz_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   // Working registers; always reloaded before use, so they need no reset.
   always_ff @(posedge clk) begin
      a_raw_q <= a_raw_d;
      b_raw_q <= b_raw_d;
      neg_q   <= neg_d;
      azero_q <= azero_d;
      bzero_q <= bzero_d;
      babs_q  <= babs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;
`ifdef ARRAY_DIV_STATUS_EN
   assign dbz    = dbz_q;
   assign ovf    = ovf_q;
`endif

endmodule
